// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// gol_pkg : shared board geometry, types and FSM states for the Life sequencer
// Revision 1.0
// ============================================================================
package gol_pkg;

  localparam int BOARD_W = 64;
  localparam int DIM     = 8;

  typedef logic [BOARD_W-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

  function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/get_next_state.sv
`default_nettype none
// ============================================================================
// get_next_state : registered Life rule for one cell of a toroidal 8x8 board
// Revision 1.0
// ============================================================================
module get_next_state
  import gol_pkg::*;
(
  input  logic [6:0]   bit_index,
  input  logic         clk,
  input  board_t       temp_reg,
  output logic         next_state
);

  logic [2:0] cx;
  logic [2:0] cy;
  logic [2:0] nx;
  logic [2:0] ny;
  logic [3:0] count;
  logic       alive;
  logic       rule_out;
  logic       unused_bit_index_msb;

  assign unused_bit_index_msb = bit_index[6];

  // 3-bit coordinate arithmetic wraps naturally, giving the torus for free.
  always_comb begin
    cx    = bit_index[2:0];
    cy    = bit_index[5:3];
    nx    = 3'd0;
    ny    = 3'd0;
    count = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          nx    = cx + 3'(dx);
          ny    = cy + 3'(dy);
          count = count + 4'(temp_reg[idx(nx, ny)]);
        end
      end
    end
    alive    = temp_reg[bit_index[5:0]];
    rule_out = (count == 4'd3) || (alive && count == 4'd2);
  end

  always_ff @(posedge clk) begin
    next_state <= rule_out;
  end

endmodule

`default_nettype wire

// File: rtl/gol_generation_sequencer.sv
`default_nettype none
// ============================================================================
// gol_generation_sequencer : steps the 8x8 toroidal Life board N generations
// Revision 1.0
// ============================================================================
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  board_t           init_board,
  input  logic             start,
  input  logic [7:0]       gens,
  output board_t           board,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  seq_state_t       state_q, state_d;
  board_t           board_q, board_d;
  board_t           next_board_q, next_board_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             done_q, done_d;
  logic             stable_q, stable_d;
  logic [5:0]       index_q, index_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [5:0]       cap_idx;
  logic             next_state;

  get_next_state u_eval (
    .bit_index  ({1'b0, index_q}),
    .clk        (clk),
    .temp_reg   (board_q),
    .next_state (next_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      board_q      <= '0;
      next_board_q <= '0;
      gen_count_q  <= '0;
      done_q       <= 1'b0;
      stable_q     <= 1'b0;
      index_q      <= 6'd0;
      remaining_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      next_board_q <= next_board_d;
      gen_count_q  <= gen_count_d;
      done_q       <= done_d;
      stable_q     <= stable_d;
      index_q      <= index_d;
      remaining_q  <= remaining_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    next_board_d = next_board_q;
    gen_count_d  = gen_count_q;
    done_d       = 1'b0;
    stable_d     = stable_q;
    index_d      = index_q;
    remaining_d  = remaining_q;
    // Evaluator output lags the issued index by one cycle; in DRAIN the
    // index has wrapped to 0, so this also yields 63 there.
    cap_idx      = index_q - 6'd1;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          board_d     = init_board;
          gen_count_d = '0;
        end else if (start) begin
          stable_d = 1'b0;
          if (gens == 8'd0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = gens;
            index_d     = 6'd0;
            state_d     = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (index_q != 6'd0) begin
          next_board_d[cap_idx] = next_state;
        end
        index_d = index_q + 6'd1;
        if (index_q == 6'd63) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        next_board_d[cap_idx] = next_state;
        state_d               = COMMIT;
      end
      COMMIT: begin
        board_d     = next_board_q;
        gen_count_d = gen_count_q + GEN_W'(1);
        remaining_d = remaining_q - 8'd1;
        if (next_board_q == board_q) begin
          stable_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (remaining_q == 8'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SWEEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign board     = board_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;

endmodule

`default_nettype wire

// File: tb/tb_gol_generation_sequencer.sv
`default_nettype none
// ============================================================================
// tb_gol_generation_sequencer : directed bench with a generation-level model
// Revision 1.0
// ============================================================================
module tb_gol_generation_sequencer;

  localparam int GEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [63:0]      init_board = '0;
  logic             start = 1'b0;
  logic [7:0]       gens = '0;
  logic [63:0]      board;
  logic             busy;
  logic             done;
  logic             stable;
  logic [GEN_W-1:0] gen_count;

  int assertions = 0;
  int failures   = 0;
  bit chk_en     = 1'b0;

  logic [63:0]      m_board  = '0;
  logic [GEN_W-1:0] m_gen    = '0;
  logic             m_busy   = 1'b0;
  logic             m_done   = 1'b0;
  logic             m_stable = 1'b0;
  int               m_rem    = 0;
  int               m_cyc    = 0;
  logic [63:0]      mid_board = '0;

  gol_generation_sequencer #(.GEN_W(GEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .init_board (init_board),
    .start      (start),
    .gens       (gens),
    .board      (board),
    .busy       (busy),
    .done       (done),
    .stable     (stable),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bits3(input int a, input int b, input int c);
    logic [63:0] r;
    r = '0;
    r[a] = 1'b1;
    r[b] = 1'b1;
    r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] life_step(input logic [63:0] b);
    logic [63:0] r;
    int n;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
              n += int'(b[((y + dy + 8) % 8) * 8 + ((x + dx + 8) % 8)]);
        r[y*8 + x] = (n == 3) || (b[y*8 + x] && n == 2);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Generation-level reference: a run is 66 busy cycles per generation.
  always @(posedge clk or posedge rst) begin
    logic [63:0] nb;
    if (rst) begin
      m_board = '0; m_gen = '0; m_busy = 1'b0; m_done = 1'b0;
      m_stable = 1'b0; m_rem = 0; m_cyc = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (load) begin
          m_board = init_board;
          m_gen   = '0;
        end else if (start) begin
          m_stable = 1'b0;
          if (gens == 8'd0) m_done = 1'b1;
          else begin
            m_busy = 1'b1;
            m_rem  = int'(gens);
            m_cyc  = 0;
          end
        end
      end else begin
        m_cyc++;
        if (m_cyc == 66) begin
          nb    = life_step(m_board);
          m_gen = m_gen + 1'b1;
          m_rem--;
          m_cyc = 0;
          if (nb == m_board) begin
            m_stable = 1'b1; m_busy = 1'b0; m_done = 1'b1;
          end else if (m_rem == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
          end
          m_board = nb;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_board",     board,            m_board);
      check("cyc_busy",      64'(busy),        64'(m_busy));
      check("cyc_done",      64'(done),        64'(m_done));
      check("cyc_stable",    64'(stable),      64'(m_stable));
      check("cyc_gen_count", 64'(gen_count),   64'(m_gen));
      check("cyc_done_busy", 64'(done & busy), 64'd0);
    end
  end

  task automatic do_load(input logic [63:0] b);
    init_board = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input logic [7:0] g, input bit inject,
                     output int done_at, output int busy_cnt);
    gens  = g;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_at  = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 2000; n++) begin
      if (busy) busy_cnt++;
      if (n == 67) mid_board = board;
      if (done) begin
        done_at = n;
        break;
      end
      if (inject && n == 10) begin
        init_board = '1; load = 1'b1; start = 1'b1;
      end
      if (inject && n == 11) begin
        load = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(done_at != 0), 64'd1);
  endtask

  initial begin
    int da, bc;
    logic [63:0] blinker_h;
    logic [63:0] blinker_v;
    logic [63:0] block;

    blinker_h = bits3(9, 10, 11);
    blinker_v = bits3(2, 10, 18);
    block     = bits3(0, 1, 8);
    block[9]  = 1'b1;

    // Pin the reference model with hand-derived generations.
    check("model_blinker", life_step(blinker_h), blinker_v);
    check("model_wrap",    life_step(bits3(7, 0, 1)), bits3(56, 0, 8));
    check("model_block",   life_step(block), block);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_board", board, 64'd0);
    check("reset_flags", {61'd0, busy, done, stable}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Blinker, one generation
    do_load(blinker_h);
    run(8'd1, 1'b0, da, bc);
    check("blinker_done_at", 64'(da), 64'd67);
    check("blinker_busy",    64'(bc), 64'd66);
    check("blinker_board",   board, blinker_v);
    check("blinker_gen",     64'(gen_count), 64'd1);
    check("blinker_stable",  64'(stable), 64'd0);
    @(negedge clk);

    // Toroidal wrap over two generations
    do_load(bits3(7, 0, 1));
    run(8'd2, 1'b0, da, bc);
    check("wrap_mid_board", mid_board, bits3(56, 0, 8));
    check("wrap_done_at",   64'(da), 64'd133);
    check("wrap_busy",      64'(bc), 64'd132);
    check("wrap_board",     board, bits3(7, 0, 1));
    check("wrap_gen",       64'(gen_count), 64'd2);
    @(negedge clk);

    // Still life stops after the first commit
    do_load(block);
    run(8'd5, 1'b0, da, bc);
    check("still_done_at", 64'(da), 64'd67);
    check("still_stable",  64'(stable), 64'd1);
    check("still_gen",     64'(gen_count), 64'd1);
    check("still_board",   board, block);
    @(negedge clk);

    // gens = 0: immediate done, no busy
    do_load(blinker_h);
    run(8'd0, 1'b0, da, bc);
    check("zero_done_at", 64'(da), 64'd1);
    check("zero_busy",    64'(bc), 64'd0);
    check("zero_stable",  64'(stable), 64'd0);
    check("zero_board",   board, blinker_h);

    // load + start together: load wins
    init_board = bits3(3, 4, 5);
    load = 1'b1; start = 1'b1; gens = 8'd1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done) bc++;
      @(negedge clk);
    end
    check("ls_board",   board, bits3(3, 4, 5));
    check("ls_no_run",  64'(bc), 64'd0);

    // load/start while busy are ignored
    do_load(blinker_h);
    run(8'd1, 1'b1, da, bc);
    check("inj_done_at", 64'(da), 64'd67);
    check("inj_board",   board, blinker_v);
    check("inj_gen",     64'(gen_count), 64'd1);
    @(negedge clk);

    // Reset mid-run
    do_load(blinker_h);
    gens = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_board", board, 64'd0);
    check("rst_flags", {61'd0, busy, done, stable}, 64'd0);
    check("rst_gen",   64'(gen_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_load(blinker_h);
    run(8'd1, 1'b0, da, bc);
    check("post_rst_done_at", 64'(da), 64'd67);
    check("post_rst_board",   board, blinker_v);
    check("post_rst_gen",     64'(gen_count), 64'd1);
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gol_generation_sequencer.md
# gol_generation_sequencer

Controller that advances the 8x8 toroidal Game of Life board by a requested number of generations. It holds the current board, sweeps every cell index through a one-cycle-latency cell evaluator, and assembles the results into the next board. It commits each generation atomically and stops early on a still life. It sits directly upstream and downstream of the per-cell evaluator: it drives the index and the board, and it consumes `next_state`.

## Interface
- `GEN_W`, default 16: width of the generation counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: in IDLE, loads `init_board` into `board`.
- `init_board` input 64: initial board; bit index = 8*y + x.
- `start` input 1: in IDLE, begins a run of `gens` generations.
- `gens` input 8: number of generations to run; sampled only when `start` is accepted.
- `board` output 64: current committed board.
- `busy` output 1: high from the first SWEEP cycle through the last COMMIT cycle of a run.
- `done` output 1: one-cycle pulse when a run ends.
- `stable` output 1: set when a run ends early on a still life; cleared when the next `start` is accepted.
- `gen_count` output GEN_W: number of generations committed since the last load.

## Operation
- Reset values: `board`=0, `next_board`=0, `gen_count`=0, `busy`=0, `done`=0, `stable`=0, state IDLE, index=0, `remaining`=0.
- IDLE:
  - `load`=1 sets `board` to `init_board` and `gen_count` to 0.
  - If `load` and `start` are both high, load wins and `start` is dropped.
  - `start`=1 with `gens`=0: no sweep; `done` pulses the next cycle; board unchanged; `stable`=0.
  - `start`=1 with `gens`>0: latch `remaining`=`gens`, clear `stable`, go to SWEEP.
- SWEEP: drive index 0..63, one per cycle, with `board` as the evaluator's board input. `board` is never written during a sweep.
- Capture: evaluator output for index i is valid one cycle after issue and is written to `next_board[i]`.
- DRAIN: one cycle, captures index 63.
- COMMIT: one cycle.
  - `board` <= `next_board`; `gen_count` increments and wraps modulo 2^GEN_W; `remaining` decrements.
  - If `next_board` == old `board`: set `stable`, pulse `done`, go to IDLE.
  - Else if `remaining` reaches 0: pulse `done`, go to IDLE.
  - Otherwise: back to SWEEP at index 0.
- `load` and `start` are ignored while `busy`.
- Async reset mid-run aborts immediately; all outputs return to reset values.

## Timing
- `start` accepted at edge k: `busy` high from cycle k+1.
- Cycles k+1..k+64 are SWEEP; cycle k+65 is DRAIN; cycle k+66 is COMMIT.
- New `board`, incremented `gen_count` and `done` all become visible together in cycle k+67, when `busy` also falls.
- Per generation: 66 cycles, no gap between generations. N generations take 66N cycles of `busy`.
- The evaluator contract is a 1-cycle registered output for an index presented with a stable board. The sequencer never changes the index and the board in the same cycle mid-sweep.
- `done` is never high while `busy` is high.

## Structure
- Shared package `gol_pkg`:
  - `BOARD_W`=64, `DIM`=8.
  - `board_t` (logic[63:0]).
  - Enum `seq_state_t` {IDLE, SWEEP, DRAIN, COMMIT}.
  - Function `idx(x,y)` = 8*y + x.
- Exactly one sub-module: the existing cell evaluator `get_next_state` (ports `bit_index`, `clk`, `temp_reg`, `next_state`).
  - Instantiated once and time-multiplexed; `bit_index` is zero-extended to 7 bits.

## Test plan
- Blinker: load bits {9,10,11}, `start` with `gens`=1.
  - `done` at k+67; `board` = bits {2,10,18}; `gen_count`=1; `stable`=0.
- Toroidal wrap: load bits {7,0,1}, `gens`=2.
  - After generation 1, `board` = bits {56,0,8}.
  - Final `board` = bits {7,0,1}; `gen_count`=2; `busy` high for exactly 132 cycles.
- Still life: load block bits {0,1,8,9}, `gens`=5.
  - Run ends after the first COMMIT: `stable`=1, `gen_count`=1, `board` unchanged, `done` at k+67.
- Boundaries:
  - `gens`=0: `done` one cycle after `start`, `busy` never rises.
  - `load`+`start` in the same cycle: board loaded, no run.
  - `start`/`load` during `busy`: ignored, board intact.
- Reset mid-run: load the blinker, `gens`=3, assert `rst` at k+30.
  - All outputs 0 immediately.
  - A subsequent load+start behaves exactly as on a fresh run.
